// File: rtl/cmac_job_sequencer_if.sv
// Job-side handshake bundle of the CMAC job sequencer: command, operand stream and result port.
// The master modport is the feeder/writeback side; the slave modport is the sequencer.
interface cmac_job_sequencer_if #(
  parameter int LEN_W = 16
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic [31:0]      cmd_init;
  logic             op_valid;
  logic             op_ready;
  logic [31:0]      op_x;
  logic [31:0]      op_y;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;

  modport master (
    output cmd_valid, cmd_len, cmd_init, op_valid, op_x, op_y, res_ready,
    input  cmd_ready, op_ready, res_valid, res_data
  );

  modport slave (
    input  cmd_valid, cmd_len, cmd_init, op_valid, op_x, op_y, res_ready,
    output cmd_ready, op_ready, res_valid, res_data
  );
endinterface

// File: rtl/cmac_job_sequencer.sv
// Sequences one packed-complex MAC job: loads the accumulator on the first beat,
// streams operand pairs, then captures the accumulated value into a one-deep result slot.
module cmac_job_sequencer #(
  parameter int LEN_W = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  cmac_job_sequencer_if.slave  job,
  output logic [31:0]          mac_x,
  output logic [31:0]          mac_y,
  output logic [31:0]          mac_accum,
  output logic                 mac_is_load,
  output logic                 mac_enable,
  input  logic [31:0]          mac_result,
  output logic                 busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_CAP  = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic [LEN_W-1:0] remaining_r;
  logic [31:0]      init_r;
  logic             first_r;
  logic             zlen_r;
  logic             cmd_ready_r;
  logic             op_ready_r;
  logic             busy_r;
  logic             res_valid_r;
  logic [31:0]      res_data_r;

  logic             cmd_fire_s;
  logic             op_fire_s;
  logic             slot_free_s;

  // Handshake qualifiers derived from the registered ready/valid flags
  always_comb begin
    cmd_fire_s  = job.cmd_valid & cmd_ready_r;
    op_fire_s   = job.op_valid & op_ready_r;
    slot_free_s = ~res_valid_r | job.res_ready;
  end

  assign job.cmd_ready = cmd_ready_r;
  assign job.op_ready  = op_ready_r;
  assign job.res_valid = res_valid_r;
  assign job.res_data  = res_data_r;
  assign busy          = busy_r;

  // The MAC only advances on an accepted operand, so a stalled stream freezes its state
  assign mac_x       = job.op_x;
  assign mac_y       = job.op_y;
  assign mac_accum   = init_r;
  assign mac_enable  = op_fire_s;
  assign mac_is_load = first_r & op_ready_r;

  // Job FSM, result slot and registered status flags
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r     <= ST_IDLE;
      remaining_r <= LEN_ZERO;
      init_r      <= 32'h0000_0000;
      first_r     <= 1'b0;
      zlen_r      <= 1'b0;
      cmd_ready_r <= 1'b1;
      op_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      res_valid_r <= 1'b0;
      res_data_r  <= 32'h0000_0000;
    end else begin
      if (res_valid_r && job.res_ready) begin
        res_valid_r <= 1'b0;
      end
      case (state_r)
        ST_IDLE: begin
          if (cmd_fire_s) begin
            init_r      <= job.cmd_init;
            remaining_r <= job.cmd_len;
            cmd_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            if (job.cmd_len == LEN_ZERO) begin
              zlen_r  <= 1'b1;
              state_r <= ST_CAP;
            end else begin
              first_r    <= 1'b1;
              zlen_r     <= 1'b0;
              op_ready_r <= 1'b1;
              state_r    <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (op_fire_s) begin
            first_r     <= 1'b0;
            remaining_r <= remaining_r - LEN_ONE;
            // Compare before decrementing so a full-length job never wraps
            if (remaining_r == LEN_ONE) begin
              op_ready_r <= 1'b0;
              state_r    <= ST_CAP;
            end
          end
        end
        ST_CAP: begin
          if (slot_free_s) begin
            res_data_r  <= zlen_r ? init_r : mac_result;
            res_valid_r <= 1'b1;
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          cmd_ready_r <= 1'b1;
          op_ready_r  <= 1'b0;
          busy_r      <= 1'b0;
          first_r     <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmac_job_sequencer.sv
// Directed bench for cmac_job_sequencer with a behavioural packed-complex MAC model;
// LEN_W=4 so the maximum job length is reachable.
module tb_cmac_job_sequencer;
  localparam int LEN_W = 4;

  logic        CLK;
  logic        RST_N;
  logic [31:0] mac_x, mac_y, mac_accum, mac_result;
  logic        mac_is_load, mac_enable, busy;
  int          n_checks, n_fail;
  int          en_cnt, load_cnt;

  cmac_job_sequencer_if #(.LEN_W(LEN_W)) bus ();

  cmac_job_sequencer #(.LEN_W(LEN_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .job(bus),
    .mac_x(mac_x), .mac_y(mac_y), .mac_accum(mac_accum),
    .mac_is_load(mac_is_load), .mac_enable(mac_enable),
    .mac_result(mac_result), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] cmul(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] re, im;
    re = 32'(a[31:16]) * 32'(b[31:16]) - 32'(a[15:0]) * 32'(b[15:0]);
    im = 32'(a[31:16]) * 32'(b[15:0]) + 32'(a[15:0]) * 32'(b[31:16]);
    return {re[15:0], im[15:0]};
  endfunction

  function automatic logic [31:0] cadd(input logic [31:0] a, input logic [31:0] b);
    logic [15:0] re, im;
    re = a[31:16] + b[31:16];
    im = a[15:0] + b[15:0];
    return {re, im};
  endfunction

  // Behavioural MAC: not reset, accumulates only on enabled edges
  initial begin
    en_cnt   = 0;
    load_cnt = 0;
  end
  always @(posedge CLK) begin
    if (mac_enable) begin
      mac_result <= cadd(mac_is_load ? mac_accum : mac_result, cmul(mac_x, mac_y));
      en_cnt     <= en_cnt + 1;
      if (mac_is_load) load_cnt <= load_cnt + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_cmd(input logic [LEN_W-1:0] len, input logic [31:0] init);
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = len;
    bus.cmd_init  = init;
    for (int i = 0; i < 20 && !bus.cmd_ready; i++) tick();
    if (!bus.cmd_ready) check_val("cmd_timeout", 32'(bus.cmd_ready), 32'd1);
    else tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic feed(input logic [31:0] x, input logic [31:0] y);
    bus.op_valid = 1'b1;
    bus.op_x     = x;
    bus.op_y     = y;
    for (int i = 0; i < 20 && !bus.op_ready; i++) tick();
    if (!bus.op_ready) check_val("op_timeout", 32'(bus.op_ready), 32'd1);
    else tick();
    bus.op_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] xs [3];
    logic [31:0] ys [3];
    logic [4:0]  pat;
    int          en_base, ld_base, b, fires;

    n_checks = 0;
    n_fail   = 0;
    RST_N = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_len = 4'd0; bus.cmd_init = 32'h0;
    bus.op_valid = 1'b0; bus.op_x = 32'h0; bus.op_y = 32'h0;
    bus.res_ready = 1'b0;
    repeat (3) tick();
    check_val("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check_val("rst_op_ready", 32'(bus.op_ready), 32'd0);
    check_val("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check_val("rst_res_data", bus.res_data, 32'h0);
    check_val("rst_busy", 32'(busy), 32'd0);
    RST_N = 1'b1;
    tick();

    // Single beat
    en_base = en_cnt; ld_base = load_cnt;
    send_cmd(4'd1, 32'h0001_0002);
    check_val("t1_busy", 32'(busy), 32'd1);
    check_val("t1_op_ready", 32'(bus.op_ready), 32'd1);
    check_val("t1_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check_val("t1_accum", mac_accum, 32'h0001_0002);
    bus.op_valid = 1'b1; bus.op_x = 32'h0003_0004; bus.op_y = 32'h0005_0006;
    #1;
    check_val("t1_en", 32'(mac_enable), 32'd1);
    check_val("t1_load", 32'(mac_is_load), 32'd1);
    check_val("t1_mac_x", mac_x, 32'h0003_0004);
    check_val("t1_mac_y", mac_y, 32'h0005_0006);
    tick();
    bus.op_valid = 1'b0;
    #1;
    check_val("t1_en_cap", 32'(mac_enable), 32'd0);
    check_val("t1_load_cap", 32'(mac_is_load), 32'd0);
    check_val("t1_rv_early", 32'(bus.res_valid), 32'd0);
    tick();
    check_val("t1_rv", 32'(bus.res_valid), 32'd1);
    check_val("t1_data", bus.res_data, 32'hFFF8_0028);
    check_val("t1_enables", 32'(en_cnt - en_base), 32'd1);
    check_val("t1_loads", 32'(load_cnt - ld_base), 32'd1);
    check_val("t1_busy_done", 32'(busy), 32'd0);
    bus.res_ready = 1'b1;
    tick();
    check_val("t1_pop", 32'(bus.res_valid), 32'd0);
    bus.res_ready = 1'b0;

    // Three beats with a stalling operand stream
    xs[0] = 32'h0001_0002; ys[0] = 32'h0003_0004;
    xs[1] = 32'h0002_0000; ys[1] = 32'h0005_0000;
    xs[2] = 32'h0000_0003; ys[2] = 32'h0000_0002;
    pat = 5'b10101;
    en_base = en_cnt; ld_base = load_cnt; b = 0;
    send_cmd(4'd3, 32'h0000_0000);
    for (int i = 0; i < 5; i++) begin
      bus.op_valid = pat[i];
      bus.op_x = xs[b]; bus.op_y = ys[b];
      #1;
      check_val("t2_en", 32'(mac_enable), 32'(pat[i]));
      if (pat[i]) begin
        check_val("t2_load", 32'(mac_is_load), (b == 0) ? 32'd1 : 32'd0);
        b++;
      end
      tick();
    end
    bus.op_valid = 1'b0;
    tick();
    check_val("t2_rv", 32'(bus.res_valid), 32'd1);
    check_val("t2_data", bus.res_data, 32'hFFFF_000A);
    check_val("t2_enables", 32'(en_cnt - en_base), 32'd3);
    check_val("t2_loads", 32'(load_cnt - ld_base), 32'd1);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;

    // Zero-length job
    en_base = en_cnt;
    send_cmd(4'd0, 32'h1234_5678);
    check_val("t3_rv_early", 32'(bus.res_valid), 32'd0);
    check_val("t3_busy", 32'(busy), 32'd1);
    check_val("t3_op_ready", 32'(bus.op_ready), 32'd0);
    tick();
    check_val("t3_rv", 32'(bus.res_valid), 32'd1);
    check_val("t3_data", bus.res_data, 32'h1234_5678);
    check_val("t3_enables", 32'(en_cnt - en_base), 32'd0);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;

    // Result backpressure while a second job completes
    send_cmd(4'd1, 32'h0000_0000);
    feed(32'h0001_0000, 32'h0001_0000);
    tick();
    check_val("t4_a_data", bus.res_data, 32'h0001_0000);
    send_cmd(4'd2, 32'h0000_0005);
    feed(32'h0002_0000, 32'h0003_0000);
    feed(32'h0000_0001, 32'h0000_0001);
    tick();
    tick();
    check_val("t4_hold_busy", 32'(busy), 32'd1);
    check_val("t4_hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check_val("t4_hold_rv", 32'(bus.res_valid), 32'd1);
    check_val("t4_hold_data", bus.res_data, 32'h0001_0000);
    bus.res_ready = 1'b1;
    tick();
    check_val("t4_b_rv", 32'(bus.res_valid), 32'd1);
    check_val("t4_b_data", bus.res_data, 32'h0005_0005);
    check_val("t4_b_busy", 32'(busy), 32'd0);
    tick();
    check_val("t4_drain", 32'(bus.res_valid), 32'd0);

    // Reset in the middle of a job
    send_cmd(4'd5, 32'h1111_1111);
    feed(32'h0001_0001, 32'h0001_0001);
    feed(32'h0001_0001, 32'h0001_0001);
    RST_N = 1'b0;
    #1;
    check_val("t5_rv", 32'(bus.res_valid), 32'd0);
    check_val("t5_busy", 32'(busy), 32'd0);
    check_val("t5_op_ready", 32'(bus.op_ready), 32'd0);
    tick();
    tick();
    RST_N = 1'b1;
    tick();
    check_val("t5_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    send_cmd(4'd1, 32'h0000_0000);
    feed(32'h0002_0003, 32'h0001_0000);
    tick();
    check_val("t5_rv_new", 32'(bus.res_valid), 32'd1);
    check_val("t5_data_new", bus.res_data, 32'h0002_0003);
    tick();

    // Maximum job length
    en_base = en_cnt; fires = 0;
    send_cmd(4'd15, 32'h0000_0000);
    bus.op_valid = 1'b1; bus.op_x = 32'h0001_0000; bus.op_y = 32'h0001_0000;
    for (int i = 0; i < 16; i++) begin
      if (bus.op_ready) fires++;
      tick();
    end
    bus.op_valid = 1'b0;
    check_val("t6_fires", 32'(fires), 32'd15);
    check_val("t6_enables", 32'(en_cnt - en_base), 32'd15);
    check_val("t6_rv", 32'(bus.res_valid), 32'd1);
    check_val("t6_data", bus.res_data, 32'h000F_0000);
    check_val("t6_idle", 32'(bus.cmd_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cmac_job_sequencer.md
Name: cmac_job_sequencer

Overview:
- Sequences the 16+16-bit packed complex multiply-accumulate unit in the mmm functional-unit path.
- Accepts a job command (initial accumulator, operand-pair count), streams operand pairs into the MAC, and drives its enable/is_load controls.
- Captures the final accumulated value and returns it over a valid/ready result port.
- Sits between the matrix-block feeder (commands and operands) and the result writeback.

Parameters:
LEN_W, 16, width of the job length field; max job length 2^LEN_W-1 operand pairs.

Ports:
CLK  input  1  clock; all state updates on posedge.
RST_N  input  1  asynchronous, active-low reset.
cmd_valid  input  1  job command valid.
cmd_ready  output  1  job command accepted when high with cmd_valid.
cmd_len  input  LEN_W  number of operand pairs in the job (0 allowed).
cmd_init  input  32  initial accumulator {real[31:16], imag[15:0]}.
op_valid  input  1  operand pair valid.
op_ready  output  1  operand pair accepted when high with op_valid.
op_x  input  32  packed complex operand x.
op_y  input  32  packed complex operand y.
res_valid  output  1  result valid.
res_ready  input  1  downstream accepts result.
res_data  output  32  final accumulated complex value.
mac_x  output  32  to MAC x; combinational pass-through of op_x.
mac_y  output  32  to MAC y; combinational pass-through of op_y.
mac_accum  output  32  to MAC accum; registered copy of cmd_init.
mac_is_load  output  1  to MAC is_load.
mac_enable  output  1  to MAC enable.
mac_result  input  32  from MAC mulAdd.
busy  output  1  high in any state other than IDLE.

Behaviour:
- MAC contract: one enabled edge registers the products and loads the accumulator (init if is_load, else the previous mac_result). With enable low, mac_result holds. After N enabled beats (first with is_load), mac_result = init + sum of products. Arithmetic is per-lane modulo 2^16, with no saturation.
- States: IDLE, RUN, CAP.
- Reset (async, RST_N=0): state=IDLE; res_valid=0, res_data=0, len/remaining/init regs=0, first=0, zlen=0.
- MAC internal registers are not reset. This is harmless because every job's first beat uses is_load.
- IDLE:
  - cmd_ready=1, op_ready=0, mac_enable=0.
  - On cmd fire: init_reg<=cmd_init, remaining<=cmd_len.
  - If cmd_len==0: zlen<=1, go to CAP.
  - Otherwise: first<=1, zlen<=0, go to RUN.
- RUN:
  - cmd_ready=0, op_ready=1.
  - mac_enable = op_valid & op_ready.
  - mac_is_load = first (only meaningful while mac_enable).
  - On op fire: first<=0, remaining<=remaining-1. If remaining==1, go to CAP.
  - op_valid low stalls with mac_enable=0, and the MAC state freezes.
- CAP:
  - op_ready=0, mac_enable=0, cmd_ready=0.
  - Slot free when !res_valid | res_ready.
  - If slot free: res_data <= zlen ? init_reg : mac_result; res_valid<=1; go to IDLE.
  - If slot not free, stay in CAP. mac_result remains stable because enable is low.
- Result port: res_valid falls on an edge with res_ready & res_valid, unless CAP loads a new result on that same edge (load wins, res_valid stays 1). res_data is stable while res_valid & !res_ready.
- Latency:
  - Last operand fire at edge k → res_valid high after edge k+1 (slot free).
  - cmd fire at edge c with len 0 → res_valid after edge c+1.
  - Minimum job turnaround is len+2 cycles.
- mac_is_load=0 and mac_enable=0 outside RUN. mac_accum is always init_reg.
- cmd_len = 2^LEN_W-1 must complete without counter wrap.
- Reset asserted mid-job: job is dropped with no result; after release, block is in IDLE with cmd_ready=1.

Test Plan:
- Single beat. Bench MAC model: integer products, low 16 bits. cmd_init=0x00010002, len=1; op_x=0x00030004, op_y=0x00050006 → exactly one beat with mac_is_load=1; res_data=0xFFF80028 one cycle after the beat.
- Three-beat job, init 0, op_valid toggled 1,0,1,0,1 → mac_enable only on fire cycles; is_load only on the first; result equals sum of the three products; 3 enables total.
- Zero length. cmd_len=0, cmd_init=0x12345678 → no mac_enable pulses; res_data=0x12345678, res_valid one cycle after cmd fire.
- Backpressure. res_ready=0 with result pending, second job of len=2 issued → second job runs, holds in CAP; first res_data stable; on res_ready=1 the first result pops, then the second loads next cycle.
- Reset. Assert RST_N low during RUN after 2 of 5 beats → immediately res_valid=0, busy=0, op_ready=0. New len=1 job after release yields correct result (is_load clears stale MAC state).
- Max length with LEN_W=4, len=15 → exactly 15 op fires, then CAP. No 16th op_ready cycle.
